bht_sat_counter_table: RTL and testbench

- Parametrised branch history table of 2^IDX_W saturating counters, each CTR_W bits wide.
- Serves the fetch stage with one registered prediction per cycle.
- Accepts one resolved-branch update per cycle from execute.
- Keeps saturating lookup and mispredict statistics for performance tuning.
- Replaces the single fixed 2-bit enable register as the predictor state store.

---
 rtl/bp_pkg.sv | 29 ++
 rtl/bht_sat_counter_table_if.sv | 29 ++
 rtl/bp_sat_ctr.sv | 30 +++
 rtl/bht_sat_counter_table.sv | 80 ++++++++
 tb/tb_bht_sat_counter_table.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared saturating-counter helpers and reset-value constants for the branch predictor.
package bp_pkg;

    localparam int unsigned CTR_W_DEF = 2;

    function automatic logic [31:0] ctr_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic logic [31:0] init_weak_nt(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] init_weak_t(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    localparam int unsigned INIT_WEAK_NT = init_weak_nt(CTR_W_DEF);
    localparam int unsigned INIT_WEAK_T  = init_weak_t(CTR_W_DEF);

    function automatic logic [31:0] sat_inc(input logic [31:0] ctr, input int unsigned w);
        return (ctr >= ctr_max(w)) ? ctr : ctr + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] ctr);
        return (ctr == 32'd0) ? ctr : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bht_sat_counter_table_if.sv
// Fetch lookup, execute update and statistics bundle of the branch history table.
interface bht_sat_counter_table_if #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned STAT_W = 16
);
    logic              pred_en;
    logic [IDX_W-1:0]  pred_idx;
    logic              pred_valid;
    logic              pred_taken;
    logic [CTR_W-1:0]  pred_ctr;
    logic              upd_en;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic              upd_mispred;
    logic              stat_clear;
    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispreds;

    modport master (
        output pred_en, pred_idx, upd_en, upd_idx, upd_taken, upd_mispred, stat_clear,
        input  pred_valid, pred_taken, pred_ctr, stat_lookups, stat_mispreds
    );

    modport slave (
        input  pred_en, pred_idx, upd_en, upd_idx, upd_taken, upd_mispred, stat_clear,
        output pred_valid, pred_taken, pred_ctr, stat_lookups, stat_mispreds
    );
endinterface

// File: rtl/bp_sat_ctr.sv
// One saturating predictor counter cell: sync reset to init, one step per enabled cycle.
module bp_sat_ctr
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             taken,
    input  logic [CTR_W-1:0] init,
    output logic [CTR_W-1:0] q
);
    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (en) begin
            ctr_d = taken ? CTR_W'(sat_inc(32'(ctr_q), CTR_W)) : CTR_W'(sat_dec(32'(ctr_q)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ctr_q <= init;
        else       ctr_q <= ctr_d;
    end

    assign q = ctr_q;
endmodule

// File: rtl/bht_sat_counter_table.sv
// Branch history table of saturating counters with registered lookup, write-first
// bypass on same-index update, and saturating lookup/mispredict statistics.
module bht_sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned INIT_VAL = INIT_WEAK_NT,
    parameter int unsigned STAT_W   = 16
) (
    input logic clk,
    input logic reset,
    bht_sat_counter_table_if.slave bus
);
    localparam int unsigned      DEPTH  = 1 << IDX_W;
    localparam logic [CTR_W-1:0] INIT_C = CTR_W'(INIT_VAL);

    logic [CTR_W-1:0]  ctr_q [DEPTH];
    logic [CTR_W-1:0]  rd_ctr;
    logic [CTR_W-1:0]  upd_next;
    logic              bypass;
    logic              pred_valid_q, pred_valid_d;
    logic [CTR_W-1:0]  pred_ctr_q, pred_ctr_d;
    logic [STAT_W-1:0] lookups_q, lookups_d;
    logic [STAT_W-1:0] mispreds_q, mispreds_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
        bp_sat_ctr #(.CTR_W(CTR_W)) u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (bus.upd_en && (bus.upd_idx == IDX_W'(i))),
            .taken (bus.upd_taken),
            .init  (INIT_C),
            .q     (ctr_q[i])
        );
    end

    // Lookup sees the value the update is writing this cycle when indices collide.
    always_comb begin
        rd_ctr   = ctr_q[bus.pred_idx];
        upd_next = bus.upd_taken ? CTR_W'(sat_inc(32'(ctr_q[bus.upd_idx]), CTR_W))
                                 : CTR_W'(sat_dec(32'(ctr_q[bus.upd_idx])));
        bypass   = bus.upd_en && (bus.upd_idx == bus.pred_idx);

        pred_valid_d = bus.pred_en;
        pred_ctr_d   = pred_ctr_q;
        if (bus.pred_en) pred_ctr_d = bypass ? upd_next : rd_ctr;

        lookups_d  = lookups_q;
        mispreds_d = mispreds_q;
        if (bus.stat_clear) begin
            lookups_d  = '0;
            mispreds_d = '0;
        end else begin
            if (bus.pred_en && (lookups_q != '1)) lookups_d = lookups_q + STAT_W'(1);
            if (bus.upd_en && bus.upd_mispred && (mispreds_q != '1))
                mispreds_d = mispreds_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
            lookups_q    <= '0;
            mispreds_q   <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_ctr_q   <= pred_ctr_d;
            lookups_q    <= lookups_d;
            mispreds_q   <= mispreds_d;
        end
    end

    assign bus.pred_valid    = pred_valid_q;
    assign bus.pred_ctr      = pred_ctr_q;
    assign bus.pred_taken    = pred_ctr_q[CTR_W-1];
    assign bus.stat_lookups  = lookups_q;
    assign bus.stat_mispreds = mispreds_q;
endmodule

// File: tb/tb_bht_sat_counter_table.sv
// Scoreboarded bench: directed scenarios on a 2-bit/STAT_W=4 table, random stream on a 3-bit table.
module tb_bht_sat_counter_table;
    import bp_pkg::*;

    typedef struct packed {
        logic        v;
        logic [31:0] ctr;
        logic        tk;
        logic [31:0] look;
        logic [31:0] mis;
    } exp_t;

    localparam int A_MAX = 3, A_SMAX = 15, A_INIT = 1;
    localparam int B_MAX = 7, B_SMAX = 65535;
    localparam int B_INIT = int'(init_weak_t(3));

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;

    bht_sat_counter_table_if #(.IDX_W(6), .CTR_W(2), .STAT_W(4))  bus_a ();
    bht_sat_counter_table_if #(.IDX_W(4), .CTR_W(3), .STAT_W(16)) bus_b ();

    bht_sat_counter_table #(.IDX_W(6), .CTR_W(2), .INIT_VAL(1), .STAT_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a));
    bht_sat_counter_table #(.IDX_W(4), .CTR_W(3), .INIT_VAL(B_INIT), .STAT_W(16)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    int   ma[64];
    int   a_v = 0, a_ctr = 0, a_l = 0, a_m = 0;
    int   mb[16];
    int   b_v = 0, b_ctr = 0, b_l = 0, b_m = 0;
    exp_t qa[$];
    exp_t qb[$];

    function automatic string fmt(input exp_t x);
        return $sformatf("v=%0d ctr=%0d tk=%0d look=%0d mis=%0d", x.v, x.ctr, x.tk, x.look, x.mis);
    endfunction

    function automatic exp_t got_a();
        exp_t g;
        g.v = bus_a.pred_valid; g.ctr = 32'(bus_a.pred_ctr); g.tk = bus_a.pred_taken;
        g.look = 32'(bus_a.stat_lookups); g.mis = 32'(bus_a.stat_mispreds);
        return g;
    endfunction

    function automatic exp_t got_b();
        exp_t g;
        g.v = bus_b.pred_valid; g.ctr = 32'(bus_b.pred_ctr); g.tk = bus_b.pred_taken;
        g.look = 32'(bus_b.stat_lookups); g.mis = 32'(bus_b.stat_mispreds);
        return g;
    endfunction

    task automatic idle_a();
        rst_a = 0; bus_a.pred_en = 0; bus_a.pred_idx = '0; bus_a.upd_en = 0; bus_a.upd_idx = '0;
        bus_a.upd_taken = 0; bus_a.upd_mispred = 0; bus_a.stat_clear = 0;
    endtask

    task automatic idle_b();
        rst_b = 0; bus_b.pred_en = 0; bus_b.pred_idx = '0; bus_b.upd_en = 0; bus_b.upd_idx = '0;
        bus_b.upd_taken = 0; bus_b.upd_mispred = 0; bus_b.stat_clear = 0;
    endtask

    // Drive one cycle on table A, advance the reference model, queue the expectation.
    task automatic cyc_a(input bit rst, input bit pe, input int pi, input bit ue, input int ui,
                         input bit ut, input bit um, input bit sc);
        exp_t e;
        int   nv;
        rst_a = rst; bus_a.pred_en = pe; bus_a.pred_idx = 6'(pi); bus_a.upd_en = ue;
        bus_a.upd_idx = 6'(ui); bus_a.upd_taken = ut; bus_a.upd_mispred = um; bus_a.stat_clear = sc;
        if (rst) begin
            foreach (ma[i]) ma[i] = A_INIT;
            a_v = 0; a_ctr = 0; a_l = 0; a_m = 0;
        end else begin
            nv = ma[ui];
            if (ue) nv = ut ? ((nv < A_MAX) ? nv + 1 : nv) : ((nv > 0) ? nv - 1 : nv);
            a_v = pe;
            if (pe) a_ctr = (ue && ui == pi) ? nv : ma[pi];
            if (sc) begin a_l = 0; a_m = 0; end
            else begin
                if (pe && a_l < A_SMAX) a_l++;
                if (ue && um && a_m < A_SMAX) a_m++;
            end
            if (ue) ma[ui] = nv;
        end
        e.v = 1'(a_v); e.ctr = 32'(a_ctr); e.tk = 1'((a_ctr >> 1) & 1);
        e.look = 32'(a_l); e.mis = 32'(a_m);
        qa.push_back(e);
        @(posedge clk); #1;
        idle_a();
    endtask

    task automatic cyc_b(input bit rst, input bit pe, input int pi, input bit ue, input int ui,
                         input bit ut, input bit um, input bit sc);
        exp_t e;
        int   nv;
        rst_b = rst; bus_b.pred_en = pe; bus_b.pred_idx = 4'(pi); bus_b.upd_en = ue;
        bus_b.upd_idx = 4'(ui); bus_b.upd_taken = ut; bus_b.upd_mispred = um; bus_b.stat_clear = sc;
        if (rst) begin
            foreach (mb[i]) mb[i] = B_INIT;
            b_v = 0; b_ctr = 0; b_l = 0; b_m = 0;
        end else begin
            nv = mb[ui];
            if (ue) nv = ut ? ((nv < B_MAX) ? nv + 1 : nv) : ((nv > 0) ? nv - 1 : nv);
            b_v = pe;
            if (pe) b_ctr = (ue && ui == pi) ? nv : mb[pi];
            if (sc) begin b_l = 0; b_m = 0; end
            else begin
                if (pe && b_l < B_SMAX) b_l++;
                if (ue && um && b_m < B_SMAX) b_m++;
            end
            if (ue) mb[ui] = nv;
        end
        e.v = 1'(b_v); e.ctr = 32'(b_ctr); e.tk = 1'((b_ctr >> 2) & 1);
        e.look = 32'(b_l); e.mis = 32'(b_m);
        qb.push_back(e);
        @(posedge clk); #1;
        idle_b();
    endtask

    task automatic test_reset();
        exp_t e, g;
        cyc_a(1, 0, 0, 0, 0, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e) begin bad++; $display("FAIL reset_state: got %s exp %s", fmt(g), fmt(e)); end
    endtask

    task automatic test_first_pred();
        exp_t e, g;
        cyc_a(0, 1, 5, 0, 0, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e) begin bad++; $display("FAIL first_pred: got %s exp %s", fmt(g), fmt(e)); end
        total++;
        if (bus_a.pred_ctr !== 2'd1 || bus_a.pred_valid !== 1'b1) begin
            bad++; $display("FAIL first_pred_init: got ctr=%0d v=%0d exp ctr=1 v=1",
                            bus_a.pred_ctr, bus_a.pred_valid);
        end
    endtask

    task automatic test_saturation();
        exp_t e, g;
        for (int k = 0; k < 4; k++) begin
            cyc_a(0, 0, 0, 1, 5, 1, 0, 0);
            e = qa.pop_front();
            cyc_a(0, 1, 5, 0, 0, 0, 0, 0);
            e = qa.pop_front(); g = got_a(); total++;
            if (g !== e) begin bad++; $display("FAIL sat_up_step%0d: got %s exp %s", k, fmt(g), fmt(e)); end
        end
        total++;
        if (bus_a.pred_ctr !== 2'd3 || bus_a.pred_taken !== 1'b1) begin
            bad++; $display("FAIL sat_up_top: got ctr=%0d tk=%0d exp ctr=3 tk=1",
                            bus_a.pred_ctr, bus_a.pred_taken);
        end
        for (int k = 0; k < 5; k++) begin
            cyc_a(0, 0, 0, 1, 5, 0, 0, 0);
            e = qa.pop_front();
        end
        cyc_a(0, 1, 5, 0, 0, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_ctr !== 2'd0) begin
            bad++; $display("FAIL sat_down_floor: got %s exp %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_collision();
        exp_t e, g;
        cyc_a(0, 1, 9, 1, 9, 1, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_ctr !== 2'd2 || bus_a.pred_taken !== 1'b1) begin
            bad++; $display("FAIL bypass_same_idx: got %s exp %s", fmt(g), fmt(e));
        end
        cyc_a(0, 1, 12, 1, 10, 1, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_ctr !== 2'd1) begin
            bad++; $display("FAIL diff_idx_pred: got %s exp %s", fmt(g), fmt(e));
        end
        cyc_a(0, 1, 10, 0, 0, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_ctr !== 2'd2) begin
            bad++; $display("FAIL diff_idx_write: got %s exp %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e, g;
        cyc_a(0, 0, 0, 1, 3, 1, 0, 0); e = qa.pop_front();
        cyc_a(0, 0, 0, 1, 3, 1, 0, 0); e = qa.pop_front();
        cyc_a(1, 1, 3, 1, 3, 1, 1, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_valid !== 1'b0) begin
            bad++; $display("FAIL reset_discard: got %s exp %s", fmt(g), fmt(e));
        end
        cyc_a(0, 1, 3, 0, 0, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.pred_ctr !== 2'd1) begin
            bad++; $display("FAIL reset_entry_init: got %s exp %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_stats();
        exp_t e, g;
        cyc_a(0, 0, 0, 0, 0, 0, 0, 1); e = qa.pop_front();
        for (int k = 0; k < 20; k++) begin
            cyc_a(0, 1, k, 0, 0, 0, 0, 0);
            e = qa.pop_front(); g = got_a(); total++;
            if (g !== e) begin bad++; $display("FAIL stat_count%0d: got %s exp %s", k, fmt(g), fmt(e)); end
        end
        total++;
        if (bus_a.stat_lookups !== 4'd15) begin
            bad++; $display("FAIL stat_lookups_sat: got %0d exp 15", bus_a.stat_lookups);
        end
        cyc_a(0, 1, 0, 0, 0, 0, 0, 1);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.stat_lookups !== 4'd0) begin
            bad++; $display("FAIL stat_clear_wins: got %s exp %s", fmt(g), fmt(e));
        end
        cyc_a(0, 0, 0, 1, 20, 1, 1, 0); e = qa.pop_front();
        cyc_a(0, 0, 0, 0, 21, 1, 1, 0); e = qa.pop_front();
        cyc_a(0, 0, 0, 1, 22, 0, 1, 0); e = qa.pop_front();
        cyc_a(0, 0, 0, 1, 23, 0, 0, 0);
        e = qa.pop_front(); g = got_a(); total++;
        if (g !== e || bus_a.stat_mispreds !== 4'd2) begin
            bad++; $display("FAIL stat_mispreds: got %s exp %s", fmt(g), fmt(e));
        end
    endtask

    task automatic test_random();
        exp_t e, g;
        int   errs = 0;
        int   pi, ui;
        cyc_b(1, 0, 0, 0, 0, 0, 0, 0);
        e = qb.pop_front(); g = got_b(); total++;
        if (g !== e) begin bad++; $display("FAIL rand_reset: got %s exp %s", fmt(g), fmt(e)); end
        for (int n = 0; n < 10000; n++) begin
            pi = int'($urandom_range(15));
            ui = ($urandom_range(3) == 0) ? pi : int'($urandom_range(15));
            cyc_b($urandom_range(499) == 0, 1'($urandom_range(1)), pi, 1'($urandom_range(1)), ui,
                  1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(99) == 0);
            e = qb.pop_front(); g = got_b(); total++;
            if (g !== e) begin
                bad++; errs++;
                if (errs <= 10) $display("FAIL rand_cycle%0d: got %s exp %s", n, fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        idle_a();
        idle_b();
        test_reset();
        test_first_pred();
        test_saturation();
        test_collision();
        test_reset_midstream();
        test_stats();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
